// File: rtl/muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_seq : iterative shift-add multiply / restoring divide, HI/LO regs  |
// | Optional: `define MULDIV_EARLY_TERM_EN for multiply early termination     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_ex,
  input  logic [1:0]       op_ex,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mf_ex,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               dz_q, dz_d;

  logic               sign_a, sign_b, b_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_part;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, calc_next, prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               early_term;

  always_comb begin
    sign_a = ~op_ex[0] & A[WIDTH-1];
    sign_b = ~op_ex[0] & B[WIDTH-1];
    abs_a  = sign_a ? -A : A;
    abs_b  = sign_b ? -B : B;
    b_zero = (B == '0);
  end

  // Multiply keeps {partial product, unconsumed multiplier}; divide keeps {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_part >= {1'b0, opnd_q});
    div_diff = div_part[WIDTH-1:0] - opnd_q;
    div_next = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                      : {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    calc_next = is_div_q ? div_next : mul_next;
`ifdef MULDIV_EARLY_TERM_EN
    early_term = 1'b0;
    begin
      logic [CW-1:0]    rem_cnt;
      logic [WIDTH-1:0] rem_mask;
      rem_cnt  = CNT_LAST - cnt_q;
      rem_mask = ~({WIDTH{1'b1}} << rem_cnt);
      if (!is_div_q && (cnt_q != CNT_LAST) && ((mul_next[WIDTH-1:0] & rem_mask) == '0)) begin
        early_term = 1'b1;
        calc_next  = mul_next >> rem_cnt;
      end
    end
`else
    early_term = 1'b0;
`endif
  end

  always_comb begin
    prod   = neg_q_q ? -acc_q : acc_q;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (dz_q) begin
      res_hi = acc_q[2*WIDTH-1:WIDTH];
      res_lo = acc_q[WIDTH-1:0];
    end else if (is_div_q) begin
      res_hi = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      res_lo = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ex && !flush) state_d = (op_ex[1] && b_zero) ? S_FIX : S_CALC;
      S_CALC: begin
        if (flush)                                state_d = S_IDLE;
        else if (cnt_q == CNT_LAST || early_term) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    stall_req   = busy & (start_ex | mf_ex | hi_we | lo_we);
    done        = (state_q == S_FIX) & ~flush;
    div_by_zero = done & dz_q;
  end

  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start_ex && !flush) begin
          cnt_d    = '0;
          is_div_d = op_ex[1];
          neg_q_d  = sign_a ^ sign_b;
          neg_r_d  = sign_a;
          dz_d     = op_ex[1] & b_zero;
          if (op_ex[1] && b_zero) begin
            acc_d = {A, {WIDTH{1'b1}}};
          end else if (op_ex[1]) begin
            acc_d  = {{WIDTH{1'b0}}, abs_a};
            opnd_d = abs_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, abs_b};
            opnd_d = abs_a;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = calc_next;
      end
      S_FIX: begin
        if (!flush) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv_seq : scoreboard bench for muldiv_seq                           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start_ex, mf_ex, hi_we, lo_we, flush;
  logic [1:0]   op_ex;
  logic [W-1:0] A, B, wdata;
  logic         busy, stall_req, done, div_by_zero;
  logic [W-1:0] HI, LO;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_ex(start_ex), .op_ex(op_ex), .A(A), .B(B),
    .mf_ex(mf_ex), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .flush(flush),
    .busy(busy), .stall_req(stall_req), .done(done), .div_by_zero(div_by_zero),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] ref_hi = '0;
  logic [W-1:0] ref_lo = '0;

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    e.dz = 1'b0;
    case (op)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        q = (sb == 0) ? 0 : sa / sb;
        r = (sb == 0) ? 0 : sa % sb;
        p = {r[31:0], q[31:0]};
      end
      default: p = (b == '0) ? 64'd0 : {a % b, a / b};
    endcase
    e.hi = p[63:32];
    e.lo = p[31:0];
    if (op[1] && b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dz = 1'b1;
    end
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_ex    = op;
    A        = a;
    B        = b;
    start_ex = 1'b1;
    sb_q.push_back(model(op, a, b));
  endtask

  // Waits for the done pulse; returns its cycle index relative to the start edge.
  task automatic wait_done(output int cyc, output logic dz, output logic seen);
    seen = 1'b0;
    cyc  = 0;
    dz   = 1'b0;
    @(posedge clk);
    #1;
    start_ex = 1'b0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc  = n;
        dz   = div_by_zero;
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b expected 0", stall_req); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", done); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got %b expected 0", div_by_zero); end
    n_checks++; if (HI !== '0) begin n_fail++; $display("FAIL reset_hi got %h expected 0", HI); end
    n_checks++; if (LO !== '0) begin n_fail++; $display("FAIL reset_lo got %h expected 0", LO); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   cyc;
    logic dz, seen;
    issue(op, a, b);
    wait_done(cyc, dz, seen);
    e = sb_q.pop_front();
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout got no done expected done within 100 cycles", name);
    end
    if (seen && e.dz) begin
      n_checks++;
      if (cyc !== 1) begin n_fail++; $display("FAIL %s_dz_latency got %0d expected 1", name, cyc); end
    end
`ifndef MULDIV_EARLY_TERM_EN
    if (seen && !e.dz) begin
      n_checks++;
      if (cyc !== W + 1) begin n_fail++; $display("FAIL %s_latency got %0d expected %0d", name, cyc, W + 1); end
    end
`endif
    n_checks++; if (dz !== e.dz) begin n_fail++; $display("FAIL %s_dz got %b expected %b", name, dz, e.dz); end
    n_checks++; if (HI !== e.hi) begin n_fail++; $display("FAIL %s_hi got %h expected %h", name, HI, e.hi); end
    n_checks++; if (LO !== e.lo) begin n_fail++; $display("FAIL %s_lo got %h expected %h", name, LO, e.lo); end
    ref_hi = e.hi;
    ref_lo = e.lo;
  endtask

  task automatic test_directed();
    test_arith("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    test_arith("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7);
    test_arith("div_neg7_2",  2'b10, 32'hFFFF_FFF9, 32'd2);
    test_arith("divu_100_7",  2'b11, 32'd100,       32'd7);
    test_arith("div_minneg",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    test_arith("div_zero",    2'b10, 32'h0000_1234, 32'd0);
    test_arith("divu_zero",   2'b11, 32'h8765_4321, 32'd0);
    test_arith("mult_min2",   2'b00, 32'h8000_0000, 32'h8000_0000);
    test_arith("div_rem_neg", 2'b10, 32'd17,        32'hFFFF_FFFB);
    test_arith("mult_zero",   2'b00, 32'd0,         32'hDEAD_BEEF);
  endtask

  task automatic test_stall();
    exp_t e;
    logic want;
    issue(2'b01, 32'd5, 32'd6);
    @(posedge clk);
    #1 start_ex = 1'b0;
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      if (n >= 3) mf_ex = 1'b1;
      #1;
      want = (n >= 3) && (n <= 33);
`ifndef MULDIV_EARLY_TERM_EN
      n_checks++;
      if (stall_req !== want) begin n_fail++; $display("FAIL stall_cyc%0d got %b expected %b", n, stall_req, want); end
`endif
      if (n == 34) begin
        n_checks++;
        if (stall_req !== 1'b0) begin n_fail++; $display("FAIL stall_idle got %b expected 0", stall_req); end
      end
    end
    mf_ex = 1'b0;
    e = sb_q.pop_front();
    n_checks++; if (LO !== e.lo) begin n_fail++; $display("FAIL stall_lo got %h expected %h", LO, e.lo); end
    n_checks++; if (HI !== e.hi) begin n_fail++; $display("FAIL stall_hi got %h expected %h", HI, e.hi); end
    ref_hi = e.hi;
    ref_lo = e.lo;
  endtask

  task automatic test_cancel(input logic use_reset);
    logic saw_done = 1'b0;
    exp_t e;
    issue(2'b11, 32'd100, 32'd7);
    e = sb_q.pop_back();
    @(posedge clk);
    #1 start_ex = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
      if (n == 10) begin
        if (use_reset) reset = 1'b1;
        else           flush = 1'b1;
      end
      if (n == 11) begin
        reset = 1'b0;
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel%0d_busy got %b expected 0", use_reset, busy); end
      end
    end
    if (use_reset) begin
      ref_hi = '0;
      ref_lo = '0;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL cancel%0d_done got %b expected 0 (res %h)", use_reset, saw_done, e.lo); end
    n_checks++; if (HI !== ref_hi) begin n_fail++; $display("FAIL cancel%0d_hi got %h expected %h", use_reset, HI, ref_hi); end
    n_checks++; if (LO !== ref_lo) begin n_fail++; $display("FAIL cancel%0d_lo got %h expected %h", use_reset, LO, ref_lo); end
  endtask

  task automatic test_mthi_mtlo();
    hi_we = 1'b1; wdata = 32'hCAFE_0001;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hCAFE_0002;
    @(negedge clk);
    lo_we = 1'b0;
    n_checks++; if (HI !== 32'hCAFE_0001) begin n_fail++; $display("FAIL mthi got %h expected cafe0001", HI); end
    n_checks++; if (LO !== 32'hCAFE_0002) begin n_fail++; $display("FAIL mtlo got %h expected cafe0002", LO); end
    ref_hi = 32'hCAFE_0001;
    ref_lo = 32'hCAFE_0002;
    // MTHI while busy must be held off
    issue(2'b11, 32'd1000, 32'd3);
    @(posedge clk);
    #1 start_ex = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 5) begin hi_we = 1'b1; wdata = 32'h1111_2222; end
      if (n == 6) begin
        #1;
        n_checks++;
        if (stall_req !== 1'b1) begin n_fail++; $display("FAIL mthi_busy_stall got %b expected 1", stall_req); end
        hi_we = 1'b0;
      end
      if (n == 8) begin
        n_checks++;
        if (HI !== ref_hi) begin n_fail++; $display("FAIL mthi_busy_hi got %h expected %h", HI, ref_hi); end
      end
    end
    begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++; if (LO !== e.lo) begin n_fail++; $display("FAIL mthi_busy_lo got %h expected %h", LO, e.lo); end
      ref_hi = e.hi;
      ref_lo = e.lo;
    end
    // Same-cycle MTHI/MTLO and start: the operation result wins
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
    test_arith("mt_with_start", 2'b01, 32'd3, 32'd4);
  endtask

  task automatic test_busy_start();
    exp_t e;
    issue(2'b01, 32'd7, 32'h8000_0009);
    @(posedge clk);
    #1;
    op_ex = 2'b11; A = 32'd1000; B = 32'd3;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 20) start_ex = 1'b0;
    end
    e = sb_q.pop_front();
    n_checks++; if (HI !== e.hi) begin n_fail++; $display("FAIL busy_start_hi got %h expected %h", HI, e.hi); end
    n_checks++; if (LO !== e.lo) begin n_fail++; $display("FAIL busy_start_lo got %h expected %h", LO, e.lo); end
    ref_hi = e.hi;
    ref_lo = e.lo;
  endtask

  task automatic test_back_to_back();
    logic [1:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      if (i == 3) b = 32'($urandom_range(1, 50));
      test_arith($sformatf("b2b%0d", i), op, a, b);
    end
  endtask

  initial begin
    reset = 1'b1; start_ex = 1'b0; op_ex = 2'b00; A = '0; B = '0;
    mf_ex = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0; flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_cancel(1'b0);
    test_cancel(1'b1);
    test_mthi_mtlo();
    test_busy_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
